// File: rtl/round_sequencer.sv
// Round sequencer for a two-player cat/dog/chicken game.
// Latches both choices, draws the round sprites and keeps score.
module round_sequencer #(
  parameter logic [3:0] WIN_SCORE = 4'd9,
  parameter logic [7:0] P1_X      = 8'd20,
  parameter logic [7:0] P2_X      = 8'd100,
  parameter logic [6:0] SPR_Y     = 7'd40,
  parameter logic [7:0] RES_X     = 8'd60,
  parameter logic [6:0] RES_Y     = 7'd90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] p1_choice,
  input  logic [2:0] p2_choice,
  output logic       draw_req,
  output logic [2:0] draw_sprite,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  input  logic       draw_done,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] result,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_P1,
    S_P2,
    S_RES,
    S_SCORE,
    S_DOVER,
    S_OVER
  } state_t;

  state_t     state_q, state_d;
  logic       req_q, req_d;
  logic [2:0] p1_q, p1_d;
  logic [2:0] p2_q, p2_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [1:0] res_q, res_d;
  logic [1:0] win;
  logic       drawing;
  logic       ack;
  logic       p1_beats;

  // Anything other than a clean one-hot choice plays as cat.
  function automatic logic [2:0] clean(input logic [2:0] c);
    case (c)
      3'b001, 3'b010, 3'b100: clean = c;
      default:                clean = 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] animal_id(input logic [2:0] c);
    case (c)
      3'b010:  animal_id = 3'd2;
      3'b100:  animal_id = 3'd3;
      default: animal_id = 3'd1;
    endcase
  endfunction

  // dog beats cat, cat beats chicken, chicken beats dog
  assign p1_beats = (p1_q[1] & p2_q[0])
                  | (p1_q[0] & p2_q[2])
                  | (p1_q[2] & p2_q[1]);

  always_comb begin
    win = 2'b10;
    if (p1_q == p2_q) win = 2'b11;
    else if (p1_beats) win = 2'b01;
  end

  assign drawing = (state_q == S_CLEAR) || (state_q == S_P1)
                || (state_q == S_P2) || (state_q == S_RES)
                || (state_q == S_DOVER);
  assign ack = req_q & draw_done;

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    res_d   = res_q;
    req_d   = drawing & ~ack;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          p1_d    = clean(p1_choice);
          p2_d    = clean(p2_choice);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: if (ack) state_d = S_P1;
      S_P1:    if (ack) state_d = S_P2;
      S_P2: begin
        if (ack) begin
          state_d = S_RES;
          res_d   = win;
        end
      end
      S_RES:   if (ack) state_d = S_SCORE;
      S_SCORE: begin
        state_d = S_IDLE;
        if (res_q == 2'b01) begin
          if (s1_q < WIN_SCORE) s1_d = s1_q + 4'd1;
          if (s1_d == WIN_SCORE) state_d = S_DOVER;
        end else if (res_q == 2'b10) begin
          if (s2_q < WIN_SCORE) s2_d = s2_q + 4'd1;
          if (s2_d == WIN_SCORE) state_d = S_DOVER;
        end
      end
      S_DOVER: if (ack) state_d = S_OVER;
      S_OVER: begin
        if (go) begin
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          res_d   = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      p1_q    <= 3'b001;
      p2_q    <= 3'b001;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      res_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      res_q   <= res_d;
    end
  end

  // Sprite fields follow the state, so they hold still for a whole request.
  always_comb begin
    draw_sprite = 3'd0;
    draw_x      = 8'd0;
    draw_y      = 7'd0;
    unique case (state_q)
      S_P1: begin
        draw_sprite = animal_id(p1_q);
        draw_x      = P1_X;
        draw_y      = SPR_Y;
      end
      S_P2: begin
        draw_sprite = animal_id(p2_q);
        draw_x      = P2_X;
        draw_y      = SPR_Y;
      end
      S_RES: begin
        draw_sprite = (res_q == 2'b01) ? 3'd4 :
                      (res_q == 2'b10) ? 3'd5 : 3'd6;
        draw_x      = RES_X;
        draw_y      = RES_Y;
      end
      S_DOVER: begin
        draw_sprite = 3'd7;
        draw_x      = RES_X;
        draw_y      = RES_Y;
      end
      default: begin
        draw_sprite = 3'd0;
        draw_x      = 8'd0;
        draw_y      = 7'd0;
      end
    endcase
  end

  assign draw_req  = req_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign result    = res_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_OVER);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed rounds from a table,
// reset/game-over sequences and random rounds against a score model.
module tb_round_sequencer;

  localparam int WIN   = 9;
  localparam int P1X   = 20;
  localparam int P2X   = 100;
  localparam int SPRY  = 40;
  localparam int RESX  = 60;
  localparam int RESY  = 90;

  localparam logic [2:0] CAT = 3'b001;
  localparam logic [2:0] DOG = 3'b010;
  localparam logic [2:0] CHK = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic [2:0] p1_choice, p2_choice;
  logic       draw_req;
  logic [2:0] draw_sprite;
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  logic       draw_done;
  logic [3:0] score1, score2;
  logic [1:0] result;
  logic       busy, game_over;

  int total = 0;
  int bad   = 0;

  int m_s1, m_s2, m_res;
  bit m_over;
  int cap[5];
  int ncap;

  typedef struct {
    logic [2:0] p1;
    logic [2:0] p2;
    int         spr1;
    int         spr2;
    int         sprres;
    int         res;
  } vec_t;

  vec_t tbl[8];

  round_sequencer dut (
    .clk(clk), .reset(reset), .go(go),
    .p1_choice(p1_choice), .p2_choice(p2_choice),
    .draw_req(draw_req), .draw_sprite(draw_sprite),
    .draw_x(draw_x), .draw_y(draw_y), .draw_done(draw_done),
    .score1(score1), .score2(score2), .result(result),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // cat=0, dog=1, chicken=2; malformed choices play as cat
  function automatic int idx(input logic [2:0] c);
    if (c == DOG) return 1;
    if (c == CHK) return 2;
    return 0;
  endfunction

  task automatic play(input logic [2:0] a, input logic [2:0] b,
                      input int dly, input bit noise);
    int ea, eb, w, d, n, cyc, len;
    int es[5], ex[5], ey[5];
    ea = idx(a);
    eb = idx(b);
    d  = (ea - eb + 3) % 3;
    w  = (d == 0) ? 3 : (d == 1) ? 1 : 2;
    es[0] = 0;      ex[0] = 0;    ey[0] = 0;
    es[1] = ea + 1; ex[1] = P1X;  ey[1] = SPRY;
    es[2] = eb + 1; ex[2] = P2X;  ey[2] = SPRY;
    es[3] = 3 + w;  ex[3] = RESX; ey[3] = RESY;
    es[4] = 7;      ex[4] = RESX; ey[4] = RESY;
    if (w == 1 && m_s1 < WIN) m_s1++;
    if (w == 2 && m_s2 < WIN) m_s2++;
    m_res  = w;
    m_over = (w == 1 && m_s1 == WIN) || (w == 2 && m_s2 == WIN);
    len    = m_over ? 5 : 4;
    go = 1'b1; p1_choice = a; p2_choice = b;
    @(negedge clk);
    go = 1'b0;
    n = 0; cyc = 0; ncap = 0;
    while (busy && cyc < 2000) begin
      if (draw_req) begin
        if (n < 5) begin
          cap[n] = int'(draw_sprite);
          chk("sprite", int'(draw_sprite), es[n]);
          chk("draw_x", int'(draw_x), ex[n]);
          chk("draw_y", int'(draw_y), ey[n]);
          if (n == 3) chk("result_at_res", int'(result), w);
        end
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          cyc++;
          if (n < 5) chk("sprite_hold", int'(draw_sprite), es[n]);
        end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        cyc++;
        chk("req_drop", int'(draw_req), 0);
        n++;
        ncap = n;
      end else begin
        if (noise) begin
          go        = 1'($urandom % 2);
          draw_done = 1'($urandom % 2);
        end
        @(negedge clk);
        go = 1'b0;
        draw_done = 1'b0;
        cyc++;
      end
    end
    chk("round_timeout", int'(cyc < 2000), 1);
    chk("draw_count", n, len);
    chk("score1", int'(score1), m_s1);
    chk("score2", int'(score2), m_s2);
    chk("result", int'(result), m_res);
    chk("game_over", int'(game_over), int'(m_over));
  endtask

  task automatic go_in_over();
    chk("in_over", int'(game_over), 1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    m_s1 = 0; m_s2 = 0; m_res = 0; m_over = 0;
    chk("over_s1", int'(score1), 0);
    chk("over_s2", int'(score2), 0);
    chk("over_res", int'(result), 0);
    chk("over_gameover", int'(game_over), 0);
    chk("over_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("over_no_req", int'(draw_req), 0);
      chk("over_idle", int'(busy), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, rounds;
    logic [2:0] ra, rb;
    tbl[0] = '{DOG,    CAT, 2, 1, 4, 1};
    tbl[1] = '{CHK,    CHK, 3, 3, 6, 3};
    tbl[2] = '{3'b011, CHK, 1, 3, 4, 1};
    tbl[3] = '{CAT,    DOG, 1, 2, 5, 2};
    tbl[4] = '{3'b000, 3'b000, 1, 1, 6, 3};
    tbl[5] = '{3'b111, DOG, 1, 2, 5, 2};
    tbl[6] = '{CHK,    DOG, 3, 2, 4, 1};
    tbl[7] = '{DOG,    CHK, 2, 3, 5, 2};

    reset = 1'b1; go = 1'b0; draw_done = 1'b0;
    p1_choice = CAT; p2_choice = CAT;
    m_s1 = 0; m_s2 = 0; m_res = 0; m_over = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_req", int'(draw_req), 0);
    chk("rst_sprite", int'(draw_sprite), 0);
    chk("rst_x", int'(draw_x), 0);
    chk("rst_y", int'(draw_y), 0);
    chk("rst_s1", int'(score1), 0);
    chk("rst_s2", int'(score2), 0);
    chk("rst_res", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_over", int'(game_over), 0);

    // IDLE holds with no go
    repeat (3) @(negedge clk);
    chk("idle_hold", int'(busy), 0);

    foreach (tbl[i]) begin
      play(tbl[i].p1, tbl[i].p2, 3, (i % 2) == 1);
      chk("tbl_p1_sprite", cap[1], tbl[i].spr1);
      chk("tbl_p2_sprite", cap[2], tbl[i].spr2);
      chk("tbl_res_sprite", cap[3], tbl[i].sprres);
      chk("tbl_result", int'(result), tbl[i].res);
    end

    // reset while DRAW_P2 has its request up, with go and done also high
    go = 1'b1; p1_choice = DOG; p2_choice = CAT;
    @(negedge clk);
    go = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 200) begin
      if (draw_req) begin
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        n++;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    while (!draw_req && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("p2_req_reached", int'(draw_req), 1);
    chk("p2_sprite_before_rst", int'(draw_sprite), 1);
    reset = 1'b1; go = 1'b1; draw_done = 1'b1;
    @(negedge clk);
    reset = 1'b0; go = 1'b0; draw_done = 1'b0;
    m_s1 = 0; m_s2 = 0; m_res = 0; m_over = 0;
    chk("midrst_req", int'(draw_req), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_s1", int'(score1), 0);
    chk("midrst_s2", int'(score2), 0);
    chk("midrst_res", int'(result), 0);
    chk("midrst_sprite", int'(draw_sprite), 0);
    @(negedge clk);
    chk("midrst_idle", int'(busy), 0);
    chk("midrst_noreq", int'(draw_req), 0);

    // P1 wins to the limit: the ninth win ends the game
    for (int r = 0; r < WIN; r++) play(DOG, CAT, r % 3, 1);
    chk("final_sprite", cap[4], 7);
    chk("final_s1", int'(score1), WIN);
    repeat (3) @(negedge clk);
    chk("over_hold", int'(game_over), 1);
    go_in_over();

    // random rounds until one player reaches the limit
    rounds = 0;
    while (!game_over && rounds < 200) begin
      if ($urandom % 4 == 0) ra = 3'($urandom % 8);
      else ra = 3'(1 << ($urandom % 3));
      if ($urandom % 4 == 0) rb = 3'($urandom % 8);
      else rb = 3'(1 << ($urandom % 3));
      play(ra, rb, int'($urandom % 5), 1);
      rounds++;
    end
    chk("rand_reached_over", int'(game_over), 1);
    go_in_over();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
